// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - two-byte instruction fetch unit with a small output buffer
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_rd_en/mem_addr  program memory read strobe and byte address
//   mem_rdata           read data, valid the cycle after mem_rd_en
//   branch_valid/target redirect from the execute stage
//   instr_valid/ready   handshake on the buffer head
//   instr_opcode/operand/pc  head instruction fields
//   program_counter_out next fetch address
//   halted              fetch stopped on a halt opcode
module instr_fetch #(
    parameter bit HALT_ON_ZERO = 1'b1,
    parameter int DEPTH        = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic       mem_rd_en,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       branch_valid,
    input  logic [7:0] branch_target,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_opcode,
    output logic [7:0] instr_operand,
    output logic [7:0] instr_pc,
    output logic [7:0] program_counter_out,
    output logic       halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        FETCH_OP,
        CAP_OP,
        CAP_ARG,
        HALT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [7:0]       pc;
    logic [7:0]       opcode_q;
    logic [7:0]       buf_pc  [DEPTH];
    logic [7:0]       buf_op  [DEPTH];
    logic [7:0]       buf_arg [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // The memory has one cycle of read latency, so the opcode is captured
    // in CAP_OP and the operand arrives in CAP_ARG, where the push happens.
    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        mem_addr   = pc;
        push       = 1'b0;
        case (state)
            FETCH_OP: begin
                if (count < DEPTH_C) begin
                    mem_rd_en  = 1'b1;
                    state_next = CAP_OP;
                end
            end
            CAP_OP: begin
                mem_rd_en  = 1'b1;
                mem_addr   = pc + 8'd1;
                state_next = CAP_ARG;
            end
            CAP_ARG: begin
                push       = 1'b1;
                state_next = (HALT_ON_ZERO && (opcode_q == 8'h00)) ? HALT : FETCH_OP;
            end
            HALT: begin
                state_next = HALT;
            end
        endcase
        // Keep the memory port quiet while reset is held.
        if (reset) begin
            mem_rd_en = 1'b0;
            mem_addr  = 8'h00;
            push      = 1'b0;
        end
    end

    assign pop = (count != '0) && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_OP;
            pc       <= 8'h00;
            opcode_q <= 8'h00;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]  <= 8'h00;
                buf_op[i]  <= 8'h00;
                buf_arg[i] <= 8'h00;
            end
        end else if (branch_valid) begin
            // Redirect wins over push/pop; any byte still arriving is ignored
            // because the FSM restarts in FETCH_OP.
            state <= FETCH_OP;
            pc    <= branch_target;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == CAP_OP) begin
                opcode_q <= mem_rdata;
            end
            if (push) begin
                buf_pc[tail]  <= pc;
                buf_op[tail]  <= opcode_q;
                buf_arg[tail] <= mem_rdata;
                tail          <= ptr_inc(tail);
                pc            <= pc + 8'd2;
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign instr_valid         = (count != '0);
    assign instr_opcode        = buf_op[head];
    assign instr_operand       = buf_arg[head];
    assign instr_pc            = buf_pc[head];
    assign program_counter_out = pc;
    assign halted              = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic [7:0] program_counter_out;
    logic       halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [256];

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] arg;
    } head_vec_t;

    head_vec_t prog_vec [4];

    instr_fetch #(.HALT_ON_ZERO(1'b1), .DEPTH(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_rd_en           (mem_rd_en),
        .mem_addr            (mem_addr),
        .mem_rdata           (mem_rdata),
        .branch_valid        (branch_valid),
        .branch_target       (branch_target),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr_opcode        (instr_opcode),
        .instr_operand       (instr_operand),
        .instr_pc            (instr_pc),
        .program_counter_out (program_counter_out),
        .halted              (halted)
    );

    always #5 clk = ~clk;

    // Program memory: one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_rd_en"}, mem_rd_en, 0);
        check({tag, " mem_addr"}, mem_addr, 8'h00);
        check({tag, " instr_valid"}, instr_valid, 0);
        check({tag, " halted"}, halted, 0);
        check({tag, " pc_out"}, program_counter_out, 8'h00);
        check({tag, " opcode"}, instr_opcode, 8'h00);
        check({tag, " operand"}, instr_operand, 8'h00);
        check({tag, " instr_pc"}, instr_pc, 8'h00);
    endtask

    task automatic wait_valid(input string tag);
        for (int c = 0; c < 40 && !instr_valid; c++) @(negedge clk);
        check({tag, " valid timeout"}, instr_valid, 1);
    endtask

    // Expects instr_ready=1: each head is compared, then popped on the next edge.
    task automatic drain(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            wait_valid(prog_vec[i].name);
            check({prog_vec[i].name, " pc"}, instr_pc, prog_vec[i].pc);
            check({prog_vec[i].name, " op"}, instr_opcode, prog_vec[i].op);
            check({prog_vec[i].name, " arg"}, instr_operand, prog_vec[i].arg);
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        branch_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        prog_vec[0] = '{"head00", 8'h00, 8'h05, 8'h00};
        prog_vec[1] = '{"head02", 8'h02, 8'h03, 8'h0A};
        prog_vec[2] = '{"head04", 8'h04, 8'h04, 8'h14};
        prog_vec[3] = '{"head06", 8'h06, 8'h00, 8'h00};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h05; mem[1] = 8'h00; mem[2] = 8'h03; mem[3] = 8'h0A;
        mem[4] = 8'h04; mem[5] = 8'h14; mem[6] = 8'h00; mem[7] = 8'h00;

        branch_target = 8'h00;
        instr_ready   = 1'b1;

        // Reset values and first fetch right after release.
        apply_reset();
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        check("first rd_en", mem_rd_en, 1);
        check("first addr", mem_addr, 8'h00);

        // Full program with a ready consumer, ending in halt.
        @(negedge clk);
        drain(0, 3);
        repeat (3) @(negedge clk);
        check("halt halted", halted, 1);
        check("halt pc_out", program_counter_out, 8'h08);
        check("halt valid", instr_valid, 0);
        for (int c = 0; c < 5; c++) begin
            check("halt rd_en", mem_rd_en, 0);
            @(negedge clk);
        end

        // Branch out of halt.
        branch_target = 8'h02;
        branch_valid  = 1'b1;
        @(negedge clk);
        branch_valid  = 1'b0;
        check("unhalt halted", halted, 0);
        check("unhalt valid", instr_valid, 0);
        check("unhalt pc_out", program_counter_out, 8'h02);
        drain(1, 3);
        repeat (3) @(negedge clk);
        check("rehalt", halted, 1);

        // Back-pressure: buffer fills to two and fetch idles.
        instr_ready = 1'b0;
        apply_reset();
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("full valid", instr_valid, 1);
        check("full head pc", instr_pc, 8'h00);
        check("full head op", instr_opcode, 8'h05);
        check("full rd_en", mem_rd_en, 0);
        check("full pc_out", program_counter_out, 8'h04);
        repeat (3) @(negedge clk);
        check("stable head pc", instr_pc, 8'h00);
        check("stable rd_en", mem_rd_en, 0);
        instr_ready = 1'b1;
        drain(0, 3);
        repeat (3) @(negedge clk);
        check("drain halted", halted, 1);

        // Branch during CAP_ARG of the instruction at 00.
        apply_reset();
        reset = 1'b0;
        @(negedge clk);
        check("capop addr", mem_addr, 8'h01);
        check("capop rd_en", mem_rd_en, 1);
        @(negedge clk);
        check("caparg valid", instr_valid, 0);
        branch_target = 8'h04;
        branch_valid  = 1'b1;
        @(negedge clk);
        branch_valid  = 1'b0;
        check("br04 pc_out", program_counter_out, 8'h04);
        check("br04 valid", instr_valid, 0);
        drain(2, 2);

        // Wrap at the top of the address space.
        mem[8'hFF] = 8'h03;
        mem[8'h00] = 8'h0A;
        branch_target = 8'hFF;
        branch_valid  = 1'b1;
        @(negedge clk);
        branch_valid  = 1'b0;
        wait_valid("wrap");
        check("wrap pc", instr_pc, 8'hFF);
        check("wrap op", instr_opcode, 8'h03);
        check("wrap arg", instr_operand, 8'h0A);
        check("wrap pc_out", program_counter_out, 8'h01);
        mem[8'h00] = 8'h05;

        // Reset asserted during CAP_OP.
        apply_reset();
        reset = 1'b0;
        @(negedge clk);
        check("pre-reset capop addr", mem_addr, 8'h01);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        #1;
        check("restart rd_en", mem_rd_en, 1);
        check("restart addr", mem_addr, 8'h00);
        @(negedge clk);
        drain(0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL be clocked by a single clock and reset by a synchronous, active-high reset; both ports follow the codebase names clk and reset.
REQ-002 Parameter HALT_ON_ZERO, default 1: when 1, a fetched opcode of 8'h00 (no-op/halt) SHALL stop further fetching.
REQ-003 Parameter DEPTH, default 2: number of entries in the output instruction buffer.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mem_rd_en  output  1  read strobe to program memory.
REQ-007 mem_addr  output  8  program memory byte address.
REQ-008 mem_rdata  input  8  read data, valid exactly one cycle after mem_rd_en.
REQ-009 branch_valid  input  1  redirect request from the execute stage.
REQ-010 branch_target  input  8  new fetch address.
REQ-011 instr_valid  output  1  buffer head holds an instruction.
REQ-012 instr_ready  input  1  execute stage accepts the head.
REQ-013 instr_opcode  output  8  opcode byte of the head.
REQ-014 instr_operand  output  8  operand/address byte of the head.
REQ-015 instr_pc  output  8  address of the head's opcode byte.
REQ-016 program_counter_out  output  8  next fetch address (internal PC).
REQ-017 halted  output  1  fetch stopped on a halt opcode.

Function
REQ-018 Each instruction SHALL be two bytes, opcode at PC and operand at PC+1.
REQ-019 The FSM SHALL have states FETCH_OP, CAP_OP, CAP_ARG and HALT.
REQ-020 FETCH_OP: if the buffer count is below DEPTH and HALT is not pending -> mem_rd_en=1, mem_addr=PC, next CAP_OP; otherwise mem_rd_en=0 and stay.
REQ-021 CAP_OP: latch mem_rdata as opcode; mem_rd_en=1, mem_addr=PC+1 (mod 256); next CAP_ARG.
REQ-022 CAP_ARG: latch mem_rdata as operand; push {PC, opcode, operand} into the buffer; PC <= PC+2 (mod 256); next HALT if HALT_ON_ZERO=1 and opcode==8'h00, else FETCH_OP.
REQ-023 A halt instruction SHALL still be pushed to the buffer; in HALT, halted=1 and mem_rd_en=0.
REQ-024 Peak throughput SHALL be one instruction per 3 cycles, with at most one fetch in flight.
REQ-025 instr_valid SHALL equal (count != 0); the head fields SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-026 A pop SHALL occur on any cycle with instr_valid & instr_ready; a simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-027 A fetch SHALL start only when count < DEPTH, so a push never overflows the buffer; a pop from an empty buffer SHALL have no effect.
REQ-028 On branch_valid=1 in any state, on the next edge: the buffer is emptied, any in-flight byte is discarded, PC <= branch_target, state <= FETCH_OP, halted <= 0.
REQ-029 branch_valid SHALL take priority over a same-cycle push and pop.
REQ-030 PC, PC+1 and PC+2 SHALL wrap modulo 256 (PC=8'hFF: operand read at 8'h00, next PC 8'h01).
REQ-031 program_counter_out SHALL always equal the internal PC.

Reset
REQ-032 When reset=1 at a rising edge: PC=8'h00, state=FETCH_OP, count=0, instr_valid=0, mem_rd_en=0, mem_addr=8'h00, halted=0, instr_opcode/operand/pc=8'h00.
REQ-033 Reset SHALL override branch_valid and abort any in-flight fetch; no push SHALL occur on the reset cycle.
REQ-034 The first mem_rd_en SHALL assert in the first cycle after reset deasserts.

Verification
REQ-035 Memory 05,00,03,0A,04,14,00,00, instr_ready=1 -> heads (pc,op,arg) = (00,05,00),(02,03,0A),(04,04,14),(06,00,00); then halted=1, program_counter_out=08, mem_rd_en stays 0.
REQ-036 Same program with instr_ready=0 -> exactly two entries buffered ((00,05,00) head), then FETCH_OP idles with mem_rd_en=0; raising instr_ready drains them in order and fetching resumes.
REQ-037 While halted, branch_valid=1 with branch_target=8'h02 -> halted=0, buffer empty, next head (02,03,0A).
REQ-038 branch_valid=1 with target 8'h04 during CAP_ARG of the instruction at 00 -> that instruction is never presented; next head (04,04,14).
REQ-039 Branch to 8'hFF with mem[FF]=03 and mem[00]=0A -> head (FF,03,0A), program_counter_out=8'h01.
REQ-040 Reset asserted during CAP_OP -> all outputs take their REQ-032 values; after release, fetch restarts at 8'h00.
